em_buf_link_resp: RTL and testbench

//  Responder side of the edit-memory buffer-chain lookup. Accepts next-buffer requests (buf_req/buf_req_ptr) from the

---
 rtl/em_buf_link_resp.sv | 153 +++++++++++++++
 tb/tb_em_buf_link_resp.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/em_buf_link_resp.sv
// Responder side of the edit-memory buffer-chain lookup.
// Queues next-buffer requests, owns the single-port link RAM, and returns the
// successor pointer for every accepted request, in order, three cycles after
// the request when nothing else is competing for the RAM.

`ifndef EM_BUF_PTR_NBITS
`define EM_BUF_PTR_NBITS 4
`endif

module em_buf_link_resp #(
    parameter int unsigned           BPTR_NBITS     = `EM_BUF_PTR_NBITS,
    parameter int unsigned           REQ_FIFO_NBITS = 3,
    parameter int unsigned           HI_WM          = 6,
    parameter logic [BPTR_NBITS-1:0] NULL_PTR       = '1
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      buf_req,
    input  logic [BPTR_NBITS-1:0]     buf_req_ptr,
    output logic                      buf_ack_valid,
    output logic [BPTR_NBITS-1:0]     buf_ack_ptr,
    input  logic                      link_wr,
    output logic                      link_wr_rdy,
    input  logic [BPTR_NBITS-1:0]     link_wr_ptr,
    input  logic [BPTR_NBITS-1:0]     link_wr_next,
    output logic                      ram_rd,
    output logic                      ram_wr,
    output logic [BPTR_NBITS-1:0]     ram_addr,
    output logic [BPTR_NBITS-1:0]     ram_wdata,
    input  logic [BPTR_NBITS-1:0]     ram_rdata,
    output logic [REQ_FIFO_NBITS:0]   req_cnt,
    output logic                      req_ovfl
);

    localparam int unsigned               DEPTH    = 1 << REQ_FIFO_NBITS;
    localparam logic [REQ_FIFO_NBITS:0]   CNT_ONE  = (REQ_FIFO_NBITS+1)'(1);
    localparam logic [REQ_FIFO_NBITS:0]   CNT_FULL = (REQ_FIFO_NBITS+1)'(DEPTH);
    localparam logic [REQ_FIFO_NBITS-1:0] PTR_ONE  = REQ_FIFO_NBITS'(1);

    logic [BPTR_NBITS-1:0]     fifo_mem [DEPTH];
    logic [REQ_FIFO_NBITS-1:0] rd_ptr, wr_ptr;
    logic [REQ_FIFO_NBITS:0]   cnt_next;

    logic                      fifo_empty, fifo_full, avail, wr_go;
    logic [BPTR_NBITS-1:0]     head;
    logic                      pop, pop_null, pop_fifo, push, drop;
    logic                      do_rd, do_wr;

    // S0/S1 lookup tags; the NULL flag lets bypassed lookups share the pipe
    logic                      s0_vld, s0_null, s1_vld, s1_null;

    // Issue arbitration: the head is the incoming request when the queue is
    // empty, so an idle lookup reaches the RAM strobes one cycle after buf_req.
    always_comb begin
        fifo_empty = (cnt_q_is_zero());
        fifo_full  = (req_cnt == CNT_FULL);
        head       = fifo_empty ? buf_req_ptr : fifo_mem[rd_ptr];
        avail      = !fifo_empty || buf_req;
        wr_go      = link_wr && link_wr_rdy;
        pop        = 1'b0;
        pop_null   = 1'b0;
        do_rd      = 1'b0;
        do_wr      = 1'b0;
        if (avail && (head == NULL_PTR)) begin
            pop      = 1'b1;
            pop_null = 1'b1;
            do_wr    = wr_go;
        end else if (wr_go) begin
            do_wr = 1'b1;
        end else if (avail) begin
            pop   = 1'b1;
            do_rd = 1'b1;
        end
        pop_fifo = pop && !fifo_empty;
        push     = buf_req && !(fifo_empty && pop) && (!fifo_full || pop);
        drop     = buf_req && fifo_full && !pop;
        cnt_next = req_cnt;
        if (push && !pop_fifo) begin
            cnt_next = req_cnt + CNT_ONE;
        end else if (!push && pop_fifo) begin
            cnt_next = req_cnt - CNT_ONE;
        end
    end

    function automatic logic cnt_q_is_zero();
        return (req_cnt == '0);
    endfunction

    // Request queue storage (no reset needed; occupancy gates every read)
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= buf_req_ptr;
        end
    end

    // Queue pointers, occupancy, sticky overflow and registered write-ready
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            req_cnt     <= '0;
            req_ovfl    <= 1'b0;
            link_wr_rdy <= 1'b1;
        end else begin
            if (push)     wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_fifo) rd_ptr <= rd_ptr + PTR_ONE;
            req_cnt     <= cnt_next;
            req_ovfl    <= req_ovfl | drop;
            link_wr_rdy <= (32'(req_cnt) < HI_WM);
        end
    end

    // Registered link RAM strobes (S0)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ram_rd    <= 1'b0;
            ram_wr    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
        end else begin
            ram_rd <= do_rd;
            ram_wr <= do_wr;
            if (do_wr) begin
                ram_addr  <= link_wr_ptr;
                ram_wdata <= link_wr_next;
            end else if (do_rd) begin
                ram_addr <= head;
            end
        end
    end

    // Lookup pipeline S0 -> S1 -> registered ack (S2)
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s0_vld        <= 1'b0;
            s0_null       <= 1'b0;
            s1_vld        <= 1'b0;
            s1_null       <= 1'b0;
            buf_ack_valid <= 1'b0;
            buf_ack_ptr   <= '0;
        end else begin
            s0_vld        <= pop;
            s0_null       <= pop_null;
            s1_vld        <= s0_vld;
            s1_null       <= s0_null;
            buf_ack_valid <= s1_vld;
            if (s1_vld) begin
                buf_ack_ptr <= s1_null ? NULL_PTR : ram_rdata;
            end
        end
    end

endmodule

// File: tb/tb_em_buf_link_resp.sv
// Self-checking bench for em_buf_link_resp: table of single lookups plus
// hand-written multi-cycle sequences. A second instance with a watermark
// above the queue depth lets continuous writes starve lookups to overflow.

module tb_em_buf_link_resp;

    localparam int unsigned     BW    = 4;
    localparam logic [BW-1:0]   NULLP = '1;

    typedef struct {
        logic [BW-1:0] ptr;
        logic          exp_rd;
        logic [BW-1:0] exp_ack;
    } vec_t;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    logic          buf_req = 1'b0;
    logic [BW-1:0] buf_req_ptr = '0;
    logic          link_wr = 1'b0;
    logic [BW-1:0] link_wr_ptr = '0;
    logic [BW-1:0] link_wr_next = '0;

    logic          m_ack_valid, m_rdy, m_ram_rd, m_ram_wr, m_req_ovfl;
    logic [BW-1:0] m_ack_ptr, m_ram_addr, m_ram_wdata;
    logic [BW-1:0] m_ram_rdata = '0;
    logic [3:0]    m_req_cnt;
    logic          o_ack_valid, o_rdy, o_ram_rd, o_ram_wr, o_req_ovfl;
    logic [BW-1:0] o_ack_ptr, o_ram_addr, o_ram_wdata;
    logic [BW-1:0] o_ram_rdata = '0;
    logic [3:0]    o_req_cnt;

    em_buf_link_resp #(.BPTR_NBITS(BW), .REQ_FIFO_NBITS(3), .HI_WM(6), .NULL_PTR(NULLP)) u_dut (
        .clk(clk), .rstn(rstn), .buf_req(buf_req), .buf_req_ptr(buf_req_ptr),
        .buf_ack_valid(m_ack_valid), .buf_ack_ptr(m_ack_ptr),
        .link_wr(link_wr), .link_wr_rdy(m_rdy), .link_wr_ptr(link_wr_ptr), .link_wr_next(link_wr_next),
        .ram_rd(m_ram_rd), .ram_wr(m_ram_wr), .ram_addr(m_ram_addr), .ram_wdata(m_ram_wdata),
        .ram_rdata(m_ram_rdata), .req_cnt(m_req_cnt), .req_ovfl(m_req_ovfl)
    );

    em_buf_link_resp #(.BPTR_NBITS(BW), .REQ_FIFO_NBITS(3), .HI_WM(9), .NULL_PTR(NULLP)) u_ovf (
        .clk(clk), .rstn(rstn), .buf_req(buf_req), .buf_req_ptr(buf_req_ptr),
        .buf_ack_valid(o_ack_valid), .buf_ack_ptr(o_ack_ptr),
        .link_wr(link_wr), .link_wr_rdy(o_rdy), .link_wr_ptr(link_wr_ptr), .link_wr_next(link_wr_next),
        .ram_rd(o_ram_rd), .ram_wr(o_ram_wr), .ram_addr(o_ram_addr), .ram_wdata(o_ram_wdata),
        .ram_rdata(o_ram_rdata), .req_cnt(o_req_cnt), .req_ovfl(o_req_ovfl)
    );

    // Link RAM models: write on the strobe edge, read data one cycle later
    logic [BW-1:0] m_mem [16] = '{default: '0};
    logic [BW-1:0] o_mem [16] = '{default: '0};
    always @(posedge clk) begin
        if (m_ram_wr) m_mem[m_ram_addr] <= m_ram_wdata;
        if (m_ram_rd) m_ram_rdata <= m_mem[m_ram_addr];
        if (o_ram_wr) o_mem[o_ram_addr] <= o_ram_wdata;
        if (o_ram_rd) o_ram_rdata <= o_mem[o_ram_addr];
    end

    // Ack collection and RAM-port exclusivity monitor
    logic [BW-1:0] m_q [$];
    logic [BW-1:0] o_q [$];
    int m_both = 0;
    int o_both = 0;
    always @(negedge clk) begin
        if (m_ack_valid) m_q.push_back(m_ack_ptr);
        if (o_ack_valid) o_q.push_back(o_ack_ptr);
        if (m_ram_rd && m_ram_wr) m_both <= m_both + 1;
        if (o_ram_rd && o_ram_wr) o_both <= o_both + 1;
    end

    int checks = 0;
    int failures = 0;

    logic [BW-1:0] lnk [14];
    vec_t          vecs [15];
    int exp_cnt4 [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 4};
    int exp_rdy4 [12] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1};

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_link(input logic [BW-1:0] p, input logic [BW-1:0] n);
        logic acc;
        acc = 1'b0;
        link_wr = 1'b1;
        link_wr_ptr = p;
        link_wr_next = n;
        for (int i = 0; i < 50 && !acc; i++) begin
            acc = m_rdy;
            tick();
        end
        link_wr = 1'b0;
        chk("link_wr_accept", acc, 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_ack_valid"}, m_ack_valid, 0);
        chk({tag, "_ack_ptr"},   m_ack_ptr, 0);
        chk({tag, "_ram_rd"},    m_ram_rd, 0);
        chk({tag, "_ram_wr"},    m_ram_wr, 0);
        chk({tag, "_req_cnt"},   m_req_cnt, 0);
        chk({tag, "_req_ovfl"},  m_req_ovfl, 0);
        chk({tag, "_wr_rdy"},    m_rdy, 1);
    endtask

    task automatic wait_acks(input int nm, input int no, input int budget);
        for (int i = 0; i < budget && (m_q.size() < nm || o_q.size() < no); i++) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        lnk = '{4'd6, 4'd4, 4'd7, 4'd15, 4'd0, 4'd9, 4'd13, 4'd1, 4'd11, 4'd12, 4'd5, 4'd8, 4'd3, 4'd10};
        vecs[0]  = '{4'd15, 1'b0, 4'd15};
        vecs[1]  = '{4'd0,  1'b1, 4'd6};
        vecs[2]  = '{4'd1,  1'b1, 4'd4};
        vecs[3]  = '{4'd2,  1'b1, 4'd7};
        vecs[4]  = '{4'd3,  1'b1, 4'd15};
        vecs[5]  = '{4'd4,  1'b1, 4'd0};
        vecs[6]  = '{4'd5,  1'b1, 4'd9};
        vecs[7]  = '{4'd6,  1'b1, 4'd13};
        vecs[8]  = '{4'd7,  1'b1, 4'd1};
        vecs[9]  = '{4'd8,  1'b1, 4'd11};
        vecs[10] = '{4'd9,  1'b1, 4'd12};
        vecs[11] = '{4'd11, 1'b1, 4'd8};
        vecs[12] = '{4'd12, 1'b1, 4'd3};
        vecs[13] = '{4'd13, 1'b1, 4'd10};
        vecs[14] = '{4'd10, 1'b1, 4'd5};

        // Reset state
        tick(); tick();
        chk_reset_vals("rst");
        rstn = 1'b1;
        tick(); tick();

        // Write 5->9 then look it up the very next cycle
        wr_link(4'd5, 4'd9);
        buf_req = 1'b1; buf_req_ptr = 4'd5;
        tick(); buf_req = 1'b0;
        chk("t1_ram_rd", m_ram_rd, 1);
        chk("t1_ram_addr", m_ram_addr, 5);
        tick();
        chk("t1_no_early_ack", m_ack_valid, 0);
        tick();
        chk("t1_ack_valid", m_ack_valid, 1);
        chk("t1_ack_ptr", m_ack_ptr, 9);
        tick();

        // Preload the link table
        for (int p = 0; p < 14; p++) wr_link(BW'(p), lnk[p]);
        tick();

        // Table of isolated lookups
        for (int i = 0; i < 15; i++) begin
            buf_req = 1'b1; buf_req_ptr = vecs[i].ptr;
            tick(); buf_req = 1'b0;
            chk($sformatf("vec%0d_ram_rd", i), m_ram_rd, vecs[i].exp_rd);
            tick(); tick();
            chk($sformatf("vec%0d_ack_valid", i), m_ack_valid, 1);
            chk($sformatf("vec%0d_ack_ptr", i), m_ack_ptr, vecs[i].exp_ack);
            tick();
            chk($sformatf("vec%0d_ack_single", i), m_ack_valid, 0);
        end

        // Back-to-back 1,2,3 -> 4,7,NULL on consecutive cycles, then hold
        buf_req = 1'b1; buf_req_ptr = 4'd1; tick();
        buf_req_ptr = 4'd2; tick();
        buf_req_ptr = 4'd3; tick();
        buf_req = 1'b0;
        chk("t2_ack0_valid", m_ack_valid, 1); chk("t2_ack0_ptr", m_ack_ptr, 4); tick();
        chk("t2_ack1_valid", m_ack_valid, 1); chk("t2_ack1_ptr", m_ack_ptr, 7); tick();
        chk("t2_ack2_valid", m_ack_valid, 1); chk("t2_ack2_ptr", m_ack_ptr, 15); tick();
        chk("t2_idle_valid", m_ack_valid, 0); chk("t2_hold_ptr", m_ack_ptr, 15);
        buf_req = 1'b1; buf_req_ptr = 4'd0; tick(); buf_req = 1'b0;
        tick(); tick(); tick();
        chk("t2_prep_ptr", m_ack_ptr, 6);

        // NULL lookup alongside a write every cycle
        link_wr = 1'b1; link_wr_ptr = 4'd14; link_wr_next = 4'd2;
        buf_req = 1'b1; buf_req_ptr = NULLP;
        tick(); buf_req = 1'b0;
        chk("t3_wr_c1", m_ram_wr, 1); chk("t3_rd_c1", m_ram_rd, 0); chk("t3_cnt", m_req_cnt, 0);
        tick();
        chk("t3_wr_c2", m_ram_wr, 1);
        tick();
        chk("t3_wr_c3", m_ram_wr, 1);
        chk("t3_ack_valid", m_ack_valid, 1);
        chk("t3_ack_ptr", m_ack_ptr, 15);
        link_wr = 1'b0;
        tick(); tick(); tick(); tick();

        // Watermark backpressure with continuous writes and 7 lookups
        m_q.delete();
        for (int k = 0; k < 12; k++) begin
            chk($sformatf("t4_cnt_c%0d", k), m_req_cnt, exp_cnt4[k]);
            chk($sformatf("t4_rdy_c%0d", k), m_rdy, exp_rdy4[k]);
            buf_req = (k < 7); buf_req_ptr = BW'(k);
            link_wr = (k < 11);
            tick();
        end
        buf_req = 1'b0; link_wr = 1'b0;
        wait_acks(7, 0, 40);
        tick(); tick(); tick();
        chk("t4_ack_count", m_q.size(), 7);
        for (int i = 0; i < 7 && i < m_q.size(); i++)
            chk($sformatf("t4_ack%0d", i), m_q[i], lnk[i]);
        chk("t4_no_ovfl", m_req_ovfl, 0);

        // Overflow: second instance never deasserts rdy, so writes starve it
        rstn = 1'b0; tick(); tick(); rstn = 1'b1; tick();
        m_q.delete(); o_q.delete();
        for (int k = 0; k < 15; k++) begin
            if (k == 8) begin
                chk("t5_o_ovfl_c8", o_req_ovfl, 0);
                chk("t5_m_cnt_c8", m_req_cnt, 7);
            end
            if (k == 9) begin
                chk("t5_o_ovfl_c9", o_req_ovfl, 1);
                chk("t5_o_cnt_c9", o_req_cnt, 8);
                chk("t5_m_cnt_c9", m_req_cnt, 7);
            end
            buf_req = (k < 9); buf_req_ptr = BW'(k);
            link_wr = (k < 14); link_wr_ptr = 4'd14; link_wr_next = 4'd2;
            tick();
        end
        buf_req = 1'b0; link_wr = 1'b0;
        wait_acks(9, 8, 60);
        for (int i = 0; i < 10; i++) tick();
        chk("t5_m_ack_count", m_q.size(), 9);
        chk("t5_o_ack_count", o_q.size(), 8);
        for (int i = 0; i < 9 && i < m_q.size(); i++)
            chk($sformatf("t5_m_ack%0d", i), m_q[i], lnk[i]);
        for (int i = 0; i < 8 && i < o_q.size(); i++)
            chk($sformatf("t5_o_ack%0d", i), o_q[i], lnk[i]);
        chk("t5_m_ovfl", m_req_ovfl, 0);
        chk("t5_o_ovfl_sticky", o_req_ovfl, 1);

        // Reset with three lookups in flight
        m_q.delete();
        buf_req = 1'b1; buf_req_ptr = 4'd0; tick();
        buf_req_ptr = 4'd1; tick();
        buf_req_ptr = 4'd2;
        #2;
        rstn = 1'b0; buf_req = 1'b0;
        #1;
        chk_reset_vals("t6_inrst");
        chk("t6_o_ovfl_cleared", o_req_ovfl, 0);
        tick(); tick(); tick();
        rstn = 1'b1;
        for (int i = 0; i < 8; i++) tick();
        chk("t6_no_stale_acks", m_q.size(), 0);
        buf_req = 1'b1; buf_req_ptr = 4'd5; tick(); buf_req = 1'b0;
        chk("t6_ram_rd", m_ram_rd, 1);
        tick(); tick();
        chk("t6_ack_valid", m_ack_valid, 1);
        chk("t6_ack_ptr", m_ack_ptr, 9);
        tick();

        chk("m_rd_wr_exclusive", m_both, 0);
        chk("o_rd_wr_exclusive", o_both, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
